// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   LSU_ADDR_W  default memory address width
//   LSU_BYTE_W  default memory word width (wide accesses are twice this)
//   lsu_state_e FSM state encoding
package lsu_pkg;

    localparam int LSU_ADDR_W = 8;
    localparam int LSU_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BYTE0 = 2'd1,
        ST_BYTE1 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit.sv
// load_store_unit: sequences byte / 16-bit little-endian loads and stores from the
// execute stage onto a byte-wide memory with async read and negedge write.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_write, req_wide        store / 16-bit access selects
//   req_addr, req_wdata        byte address (low byte for wide) and store data
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_fault     load data (0 for stores) and fault flag
//   mem_address, mem_data_in,
//   mem_write_enable           registered memory controls
//   mem_data_out               async memory read data
//
// Build option: LSU_WRAP_FAULT_EN -- a wide access at the top address faults instead
// of wrapping to address 0, and performs no memory cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request
// BYTE0 | memory cycle on the low byte (addr)
// BYTE1 | memory cycle on the high byte (addr+1, wrapping), wide only
// RESP  | resp_valid pulse; a new request may be accepted here too
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = LSU_ADDR_W,
    parameter int BYTE_W = LSU_BYTE_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic                req_wide,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*BYTE_W-1:0] req_wdata,
    output logic                resp_valid,
    output logic [2*BYTE_W-1:0] resp_rdata,
    output logic                resp_fault,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [BYTE_W-1:0]   mem_data_in,
    output logic                mem_write_enable,
    input  logic [BYTE_W-1:0]   mem_data_out
);

    lsu_state_e          state_q, state_d;
    logic                write_q, write_d;
    logic                wide_q, wide_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2*BYTE_W-1:0] wdata_q, wdata_d;
    logic [2*BYTE_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [BYTE_W-1:0]   mem_data_in_q, mem_data_in_d;
    logic                mem_we_q, mem_we_d;
`ifdef LSU_WRAP_FAULT_EN
    logic                fault_q, fault_d;
`endif
    logic                accept;

    // The response cycle also accepts, so a held request restarts on the edge leaving RESP.
    assign req_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d       = state_q;
        write_d       = write_q;
        wide_d        = wide_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        mem_we_d      = 1'b0;
`ifdef LSU_WRAP_FAULT_EN
        fault_d       = fault_q;
`endif
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (accept) begin
                    write_d = req_write;
                    wide_d  = req_wide;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
`ifdef LSU_WRAP_FAULT_EN
                    fault_d = 1'b0;
                    if (req_wide && (req_addr == {ADDR_W{1'b1}})) begin
                        // No memory cycle: answer straight away with a fault.
                        fault_d = 1'b1;
                        state_d = ST_RESP;
                    end else
`endif
                    begin
                        // Memory controls are loaded here so they are valid for all of BYTE0.
                        state_d       = ST_BYTE0;
                        mem_address_d = req_addr;
                        mem_data_in_d = req_wdata[BYTE_W-1:0];
                        mem_we_d      = req_write;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BYTE0: begin
                if (!write_q) rdata_d[BYTE_W-1:0] = mem_data_out;
                if (wide_q) begin
                    state_d       = ST_BYTE1;
                    mem_address_d = addr_q + 1'b1;
                    mem_data_in_d = wdata_q[2*BYTE_W-1:BYTE_W];
                    mem_we_d      = write_q;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_BYTE1: begin
                if (!write_q) rdata_d[2*BYTE_W-1:BYTE_W] = mem_data_out;
                state_d = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            write_q       <= 1'b0;
            wide_q        <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_we_q      <= 1'b0;
`ifdef LSU_WRAP_FAULT_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            write_q       <= write_d;
            wide_q        <= wide_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_we_q      <= mem_we_d;
`ifdef LSU_WRAP_FAULT_EN
            fault_q       <= fault_d;
`endif
        end
    end

    assign resp_valid       = (state_q == ST_RESP);
    assign resp_rdata       = rdata_q;
    assign mem_address      = mem_address_q;
    assign mem_data_in      = mem_data_in_q;
    assign mem_write_enable = mem_we_q;
`ifdef LSU_WRAP_FAULT_EN
    assign resp_fault       = fault_q;
`else
    assign resp_fault       = 1'b0;
`endif

endmodule
